// File: rtl/gol_sim_sequencer.sv
// Generation sequencer for the Game of Life datapath: arbitrates clear/config loads,
// run/pause/single-step control and frame-paced generations, and owns field select + counter.
module gol_sim_sequencer #(
    parameter int NUM_CFG        = 2,
    parameter int FRAMES_PER_GEN = 4,
    parameter int GEN_W          = 16,
    parameter int SEL_W          = $clog2(NUM_CFG + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_cmd_toggle_pause,
    input  logic               i_cmd_step,
    input  logic               i_cmd_clear,
    input  logic [NUM_CFG-1:0] i_cmd_load_cfg,
    input  logic               i_frame_start,
    input  logic               i_sim_busy,
    input  logic               i_load_busy,
    output logic               o_sim_go,
    output logic               o_load_go,
    output logic [SEL_W-1:0]   o_load_sel,
    output logic               o_read_field,
    output logic               o_paused,
    output logic [GEN_W-1:0]   o_generation,
    output logic               o_busy
);

    localparam int               CNT_W    = $clog2(FRAMES_PER_GEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAMES_PER_GEN);

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_LOAD_GO, ST_LOAD_ACK,
        ST_LOAD_RUN, ST_SIM_GO, ST_SIM_ACK, ST_SIM_RUN
    } state_t;

    state_t             r_state;
    logic               r_pend_load_vld;
    logic [SEL_W-1:0]   r_pend_load_sel;
    logic               r_pend_step;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               r_paused;
    logic               r_read_field;
    logic [GEN_W-1:0]   r_generation;
    logic               r_sim_go;
    logic               r_load_go;
    logic [SEL_W-1:0]   r_load_sel;
    logic               r_busy;

    logic               w_req_vld;
    logic [SEL_W-1:0]   w_req_sel;
    logic               w_frame_tick;
    logic               w_gen_due;

    // Clear beats any config; among configs the lowest index wins.
    always_comb begin
        w_req_vld = i_cmd_clear | (|i_cmd_load_cfg);
        w_req_sel = '0;
        for (int k = NUM_CFG - 1; k >= 0; k--) begin
            if (i_cmd_load_cfg[k]) w_req_sel = SEL_W'(k + 1);
        end
        if (i_cmd_clear) w_req_sel = '0;
        w_frame_tick = i_frame_start & ~r_paused;
        w_gen_due    = ~r_paused & (r_frame_cnt == CNT_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_INIT;
            r_pend_load_vld <= 1'b1;
            r_pend_load_sel <= '0;
            r_pend_step     <= 1'b0;
            r_frame_cnt     <= '0;
            r_paused        <= 1'b1;
            r_read_field    <= 1'b0;
            r_generation    <= '0;
            r_sim_go        <= 1'b0;
            r_load_go       <= 1'b0;
            r_load_sel      <= '0;
            r_busy          <= 1'b1;
        end else begin
            r_sim_go  <= 1'b0;
            r_load_go <= 1'b0;

            if (i_cmd_toggle_pause) r_paused <= ~r_paused;
            if (w_frame_tick && (r_frame_cnt != CNT_FULL)) r_frame_cnt <= r_frame_cnt + CNT_W'(1);

            case (r_state)
                ST_INIT: begin
                    r_pend_load_vld <= 1'b1;
                    r_pend_load_sel <= '0;
                    r_state         <= ST_IDLE;
                    r_busy          <= 1'b0;
                end
                ST_IDLE: begin
                    if (r_pend_load_vld) begin
                        r_load_go       <= 1'b1;
                        r_load_sel      <= r_pend_load_sel;
                        r_pend_load_vld <= 1'b0;
                        r_state         <= ST_LOAD_GO;
                        r_busy          <= 1'b1;
                    end else if (r_pend_step || w_gen_due) begin
                        r_sim_go    <= 1'b1;
                        r_pend_step <= 1'b0;
                        r_frame_cnt <= w_frame_tick ? CNT_W'(1) : '0;
                        r_state     <= ST_SIM_GO;
                        r_busy      <= 1'b1;
                    end
                end
                ST_LOAD_GO:  r_state <= ST_LOAD_ACK;
                ST_LOAD_ACK: if (i_load_busy) r_state <= ST_LOAD_RUN;
                ST_LOAD_RUN: begin
                    if (!i_load_busy) begin
                        r_generation <= '0;
                        r_frame_cnt  <= '0;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                ST_SIM_GO:  r_state <= ST_SIM_ACK;
                ST_SIM_ACK: if (i_sim_busy) r_state <= ST_SIM_RUN;
                ST_SIM_RUN: begin
                    if (!i_sim_busy) begin
                        r_read_field <= ~r_read_field;
                        r_generation <= r_generation + GEN_W'(1);
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_busy  <= 1'b1;
                end
            endcase

            // NOTE: the last non-blocking assignment to a register wins, so request latching sits
            // after the FSM: a request arriving as the pending slot is consumed is kept, not lost.
            if (w_req_vld) begin
                r_pend_load_vld <= 1'b1;
                r_pend_load_sel <= w_req_sel;
            end
            if (i_cmd_step && r_paused) r_pend_step <= 1'b1;
            if (i_cmd_toggle_pause && r_paused) r_pend_step <= 1'b0;
        end
    end

    assign o_sim_go     = r_sim_go;
    assign o_load_go    = r_load_go;
    assign o_load_sel   = r_load_sel;
    assign o_read_field = r_read_field;
    assign o_paused     = r_paused;
    assign o_generation = r_generation;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_gol_sim_sequencer.sv
// Bench for gol_sim_sequencer: transaction-level model of pause/step/pacing/load rules,
// directed scenarios plus a randomized command stream; a GEN_W=2 copy checks counter wrap.
module tb_gol_sim_sequencer;

    localparam int NUM_CFG = 2;
    localparam int FPG     = 4;
    localparam int SEL_W   = $clog2(NUM_CFG + 1);

    logic               clk;
    logic               rst_n;
    logic               i_cmd_toggle_pause;
    logic               i_cmd_step;
    logic               i_cmd_clear;
    logic [NUM_CFG-1:0] i_cmd_load_cfg;
    logic               i_frame_start;
    logic               i_sim_busy;
    logic               i_load_busy;

    logic               o_sim_go, o_load_go, o_read_field, o_paused, o_busy;
    logic [SEL_W-1:0]   o_load_sel;
    logic [15:0]        o_generation;

    logic               o_sim_go_w2, o_load_go_w2, o_read_field_w2, o_paused_w2, o_busy_w2;
    logic [SEL_W-1:0]   o_load_sel_w2;
    logic [1:0]         o_generation_w2;

    gol_sim_sequencer #(.NUM_CFG(NUM_CFG), .FRAMES_PER_GEN(FPG), .GEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_toggle_pause(i_cmd_toggle_pause), .i_cmd_step(i_cmd_step),
        .i_cmd_clear(i_cmd_clear), .i_cmd_load_cfg(i_cmd_load_cfg),
        .i_frame_start(i_frame_start), .i_sim_busy(i_sim_busy), .i_load_busy(i_load_busy),
        .o_sim_go(o_sim_go), .o_load_go(o_load_go), .o_load_sel(o_load_sel),
        .o_read_field(o_read_field), .o_paused(o_paused),
        .o_generation(o_generation), .o_busy(o_busy)
    );

    gol_sim_sequencer #(.NUM_CFG(NUM_CFG), .FRAMES_PER_GEN(FPG), .GEN_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_toggle_pause(i_cmd_toggle_pause), .i_cmd_step(i_cmd_step),
        .i_cmd_clear(i_cmd_clear), .i_cmd_load_cfg(i_cmd_load_cfg),
        .i_frame_start(i_frame_start), .i_sim_busy(i_sim_busy), .i_load_busy(i_load_busy),
        .o_sim_go(o_sim_go_w2), .o_load_go(o_load_go_w2), .o_load_sel(o_load_sel_w2),
        .o_read_field(o_read_field_w2), .o_paused(o_paused_w2),
        .o_generation(o_generation_w2), .o_busy(o_busy_w2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model state
    bit m_paused = 1'b1;
    bit m_field  = 1'b0;
    int m_gen    = 0;
    int m_cnt    = 0;
    int exp_sim  = 0;
    int exp_load = 0;
    int exp_sel  = 0;

    // Observed go pulses
    int n_sim = 0, n_load = 0, last_sel = 0;
    int n_sim_w2 = 0, n_load_w2 = 0, last_sel_w2 = 0;
    bit prev_sim = 1'b0, prev_load = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_sim_go) begin
                    check("sim_go_width", prev_sim, 0);
                    n_sim++;
                end
                if (o_load_go) begin
                    check("load_go_width", prev_load, 0);
                    n_load++;
                    last_sel = o_load_sel;
                end
                if (o_sim_go_w2) n_sim_w2++;
                if (o_load_go_w2) begin
                    n_load_w2++;
                    last_sel_w2 = o_load_sel_w2;
                end
            end
            prev_sim  = o_sim_go;
            prev_load = o_load_go;
        end
    end

    // Loader / iterator responders: busy after a short delay, for a bounded length
    int ld_wait = 0, ld_left = 0, sm_wait = 0, sm_left = 0;
    int sim_lo = 1, sim_hi = 6;

    initial begin
        i_load_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i_load_busy = 1'b0; ld_wait = 0; ld_left = 0;
            end else if (ld_left > 0) begin
                ld_left--;
                if (ld_left == 0) i_load_busy = 1'b0;
            end else if (ld_wait > 0) begin
                ld_wait--;
                if (ld_wait == 0) begin
                    i_load_busy = 1'b1;
                    ld_left = $urandom_range(6, 1);
                end
            end else if (o_load_go) begin
                ld_wait = $urandom_range(3, 1);
            end
        end
    end

    initial begin
        i_sim_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i_sim_busy = 1'b0; sm_wait = 0; sm_left = 0;
            end else if (sm_left > 0) begin
                sm_left--;
                if (sm_left == 0) i_sim_busy = 1'b0;
            end else if (sm_wait > 0) begin
                sm_wait--;
                if (sm_wait == 0) begin
                    i_sim_busy = 1'b1;
                    sm_left = $urandom_range(sim_hi, sim_lo);
                end
            end else if (o_sim_go) begin
                sm_wait = $urandom_range(3, 1);
            end
        end
    end

    function automatic int prio_sel(input logic clr, input logic [NUM_CFG-1:0] cfg);
        if (clr) return 0;
        for (int k = 0; k < NUM_CFG; k++) if (cfg[k]) return k + 1;
        return 0;
    endfunction

    task automatic drive_cmd(input logic tog, input logic stp, input logic clr,
                             input logic [NUM_CFG-1:0] cfg, input logic frm);
        @(negedge clk);
        i_cmd_toggle_pause = tog; i_cmd_step = stp; i_cmd_clear = clr;
        i_cmd_load_cfg = cfg; i_frame_start = frm;
        @(negedge clk);
        i_cmd_toggle_pause = 1'b0; i_cmd_step = 1'b0; i_cmd_clear = 1'b0;
        i_cmd_load_cfg = '0; i_frame_start = 1'b0;
    endtask

    // Wait until DUT and responders have been quiet for several consecutive cycles
    task automatic settle(input string tag);
        int n = 0;
        int q = 0;
        while (q < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (o_busy || o_busy_w2 || i_load_busy || i_sim_busy || ld_wait > 0 || sm_wait > 0) q = 0;
            else q++;
        end
        check({tag, ":settle"}, int'(q >= 4), 1);
    endtask

    task automatic check_state(input string tag);
        check({tag, ":paused"}, o_paused, m_paused);
        check({tag, ":field"}, o_read_field, m_field);
        check({tag, ":gen"}, o_generation, m_gen % 65536);
        check({tag, ":busy"}, o_busy, 0);
        check({tag, ":n_sim"}, n_sim, exp_sim);
        check({tag, ":n_load"}, n_load, exp_load);
        if (exp_load > 0) check({tag, ":sel"}, last_sel, exp_sel);
        check({tag, ":w2_gen"}, o_generation_w2, m_gen % 4);
        check({tag, ":w2_field"}, o_read_field_w2, m_field);
        check({tag, ":w2_n_sim"}, n_sim_w2, exp_sim);
        check({tag, ":w2_n_load"}, n_load_w2, exp_load);
        if (exp_load > 0) check({tag, ":w2_sel"}, last_sel_w2, exp_sel);
    endtask

    task automatic do_op(input string tag, input logic tog, input logic stp, input logic clr,
                         input logic [NUM_CFG-1:0] cfg, input logic frm);
        bit sim = 1'b0;
        drive_cmd(tog, stp, clr, cfg, frm);
        if (clr || cfg != '0) begin
            exp_load++;
            exp_sel = prio_sel(clr, cfg);
            m_gen = 0;
            m_cnt = 0;
        end
        if (stp && !tog && m_paused) sim = 1'b1;
        if (frm && !m_paused) begin
            if (m_cnt < FPG) m_cnt++;
            if (m_cnt == FPG) sim = 1'b1;
        end
        if (tog) m_paused = !m_paused;
        if (sim) begin
            exp_sim++;
            m_gen++;
            m_field = !m_field;
            m_cnt = 0;
        end
        settle(tag);
        check_state(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":rst_paused"}, o_paused, 1);
        check({tag, ":rst_field"}, o_read_field, 0);
        check({tag, ":rst_gen"}, o_generation, 0);
        check({tag, ":rst_sim_go"}, o_sim_go, 0);
        check({tag, ":rst_load_go"}, o_load_go, 0);
        check({tag, ":rst_sel"}, o_load_sel, 0);
        check({tag, ":rst_busy"}, o_busy, 1);
        check({tag, ":rst_w2_busy"}, o_busy_w2, 1);
    endtask

    task automatic model_reset();
        m_paused = 1'b1; m_field = 1'b0; m_gen = 0; m_cnt = 0;
        exp_load++;
        exp_sel = 0;
    endtask

    task automatic wait_sim_go(input string tag);
        int n = 0;
        while (!o_sim_go && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":go_seen"}, o_sim_go, 1);
    endtask

    initial begin
        int r;
        logic [NUM_CFG-1:0] cfg;
        logic clr;

        rst_n = 1'b0;
        i_cmd_toggle_pause = 1'b0; i_cmd_step = 1'b0; i_cmd_clear = 1'b0;
        i_cmd_load_cfg = '0; i_frame_start = 1'b0;

        // Reset state, then the automatic clear load
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        model_reset();
        settle("post_reset");
        check_state("post_reset");

        // Paused single step with a long iteration, then frames must not start anything
        sim_lo = 10; sim_hi = 10;
        do_op("step1", 1'b0, 1'b1, 1'b0, '0, 1'b0);
        sim_lo = 1; sim_hi = 6;
        for (int i = 0; i < 20; i++) do_op("paused_frame", 1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Running: one generation per FPG frames
        do_op("clear_a", 1'b0, 1'b0, 1'b1, '0, 1'b0);
        do_op("unpause", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 12; i++) do_op("run_frame", 1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("run_gen3", o_generation, 3);
        do_op("step_ignored", 1'b0, 1'b1, 1'b0, '0, 1'b0);

        // Two loads requested during a generation: last one wins, served after it
        do_op("pause", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        sim_lo = 12; sim_hi = 12;
        begin
            int loads_before;
            loads_before = n_load;
            drive_cmd(1'b0, 1'b1, 1'b0, '0, 1'b0);
            wait_sim_go("mid_sim");
            repeat (1) @(negedge clk);
            drive_cmd(1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
            drive_cmd(1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
            check("mid_sim:inflight", o_busy, 1);
            check("mid_sim:no_load_yet", n_load, loads_before);
            exp_sim++; m_gen++; m_field = !m_field;
            exp_load++; exp_sel = 2; m_gen = 0; m_cnt = 0;
            settle("mid_sim");
            check_state("mid_sim");
        end
        sim_lo = 1; sim_hi = 6;

        // Same-cycle request priority
        do_op("clr_and_cfg11", 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        do_op("cfg11", 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        do_op("cfg10", 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);

        // Wrap of the 2-bit counter over five steps, and step+toggle while paused
        do_op("clear_b", 1'b0, 1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 5; i++) do_op("wrap_step", 1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("wrap_w2_gen", o_generation_w2, 1);
        do_op("step_and_unpause", 1'b1, 1'b1, 1'b0, '0, 1'b0);
        do_op("repause", 1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Reset in the middle of a generation reissues the clear
        sim_lo = 20; sim_hi = 20;
        drive_cmd(1'b0, 1'b1, 1'b0, '0, 1'b0);
        wait_sim_go("mid_rst");
        exp_sim++;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sim_lo = 1; sim_hi = 6;
        settle("mid_rst");
        check_state("mid_rst");

        // Randomized command stream
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(9, 0);
            case (r)
                0, 1, 2, 3, 4: do_op("rnd_frame", 1'b0, 1'b0, 1'b0, '0, 1'b1);
                5: do_op("rnd_step", 1'b0, 1'b1, 1'b0, '0, 1'b0);
                6: do_op("rnd_toggle", 1'b1, 1'b0, 1'b0, '0, 1'b0);
                7: do_op("rnd_step_toggle", 1'b1, 1'b1, 1'b0, '0, 1'b0);
                default: begin
                    clr = 1'($urandom_range(1, 0));
                    cfg = NUM_CFG'($urandom_range(3, 0));
                    if (!clr && cfg == '0) cfg = 2'b10;
                    do_op("rnd_load", 1'b0, 1'b0, clr, cfg, 1'b0);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gol_sim_sequencer.md
# gol_sim_sequencer

Parametrised generation sequencer for the Game of Life datapath, sitting between the filtered button commands and the next-field iterator / config loader pair. It supersedes the fixed two-config, free-running control path. It arbitrates N config-load requests plus clear, supports run/pause/single-step modes, and paces generations to VGA frame starts. It also owns the ping-pong read-field select and a wrapping generation counter.

## Interface
- NUM_CFG, 2, number of config ROMs (1..15); load select 0 = clear, 1..NUM_CFG = config k
- FRAMES_PER_GEN, 4, VGA frames per generation while running (1..255)
- GEN_W, 16, generation counter width
- SEL_W, $clog2(NUM_CFG+1), load select width (derived)
- clk  in  1  system clock (VGA pixel clock)
- rst_n  in  1  reset; synchronous, active-low (one clock; reset is synchronous and active-low)
- i_cmd_toggle_pause  in  1  single-cycle pulse, toggles run/pause
- i_cmd_step  in  1  single-cycle pulse, one generation when paused
- i_cmd_clear  in  1  single-cycle pulse, request load of empty field
- i_cmd_load_cfg  in  NUM_CFG  one-hot-ish pulses, bit k requests config k+1
- i_frame_start  in  1  one-cycle pulse per VGA frame
- i_sim_busy  in  1  iterator busy
- i_load_busy  in  1  loader busy
- o_sim_go  out  1  one-cycle iterator start pulse
- o_load_go  out  1  one-cycle loader start pulse
- o_load_sel  out  SEL_W  select for current/last load, stable from o_load_go until load done
- o_read_field  out  1  0 = field A is read/displayed, 1 = field B
- o_paused  out  1  pause state
- o_generation  out  GEN_W  generations since last completed load
- o_busy  out  1  high in any state other than IDLE

## Operation
- States: INIT, IDLE, LOAD_GO, LOAD_ACK, LOAD_RUN, SIM_GO, SIM_ACK, SIM_RUN.
- INIT: entered on reset; sets pending load = clear; goes to IDLE next cycle. After reset, field memory is cleared before anything else runs.
- Load requests are latched into a single pending slot in any state.
  - Same-cycle priority: clear > lowest cfg bit.
  - A later request overwrites an earlier pending one (last wins).
- IDLE priority: pending load > pending step > due generation.
- Load: LOAD_GO drives o_load_go=1 and o_load_sel=pending, then clears pending.
  - LOAD_ACK waits for i_load_busy=1; LOAD_RUN waits for i_load_busy=0.
  - On done: o_generation←0, frame count←0, return to IDLE.
  - The loader writes the field selected by o_read_field; o_read_field is unchanged.
- Pause: i_cmd_toggle_pause flips o_paused in any state and takes effect at the next IDLE decision.
- Step: i_cmd_step is latched only when o_paused=1 and is ignored while running. A pending step is cleared on unpause.
- Pacing: the frame counter increments on i_frame_start while not paused, saturating at FRAMES_PER_GEN. A generation is due when count==FRAMES_PER_GEN.
- Simulation: SIM_GO drives o_sim_go=1 and clears the frame count and pending step.
  - SIM_ACK waits for i_sim_busy=1; SIM_RUN waits for i_sim_busy=0.
  - On done: o_read_field toggles, o_generation+1 (wraps 2^GEN_W-1→0), return to IDLE.
- Only one of sim/load is ever in flight. A load requested mid-generation is served after the generation completes.
- Simultaneous i_cmd_step and i_cmd_toggle_pause while paused: step is latched, then pause clears it. Net effect is run mode with no pending step.

## Timing
- Reset values (cycle after rst_n sampled low):
  - state=INIT; o_paused=1; o_read_field=0; o_generation=0.
  - o_sim_go=0; o_load_go=0; o_load_sel=0; o_busy=1.
  - Pending load=clear; no pending step; frame count=0.
- All outputs are registered. o_sim_go/o_load_go are high for exactly one cycle, one cycle after IDLE's decision.
- Reset asserted mid-operation aborts any in-flight sim or load and restarts at INIT, with the clear reissued.
- A request pulse landing in the same cycle as IDLE's decision is considered on the next IDLE cycle (latency ≤ 1 extra cycle).
- o_read_field and o_generation update in the same cycle IDLE is re-entered.

## Test plan
- Reset release, loader pulses busy 3 cycles after go:
  - o_load_go once with sel=0.
  - After busy falls: o_generation=0, o_paused=1, o_read_field=0, o_busy=0.
- Paused, cmd_step ×1, sim busy 10 cycles:
  - Exactly one o_sim_go.
  - o_read_field 0→1, o_generation=1.
  - No further go over 20 frame_start pulses.
- Unpause with FRAMES_PER_GEN=4, 12 frame_start pulses, fast sim: exactly 3 o_sim_go, each after the 4th frame since the last go; o_generation=3.
- During SIM_RUN, pulse i_cmd_load_cfg[0] then i_cmd_load_cfg[1]:
  - Single o_load_go with sel=2 after sim done.
  - o_generation=0 after load.
- Same-cycle i_cmd_clear + i_cmd_load_cfg=2'b11 in IDLE: o_load_sel=0.
- GEN_W=2, 5 steps: o_generation sequence 1,2,3,0,1; o_read_field toggles every generation.
